// File: rtl/cache_line_mem_ctrl_pkg.sv
// Shared types and sizing for the cache-line memory initiator: line operations,
// controller states and the single-word Memory request/response records.
package cache_line_mem_ctrl_pkg;
    localparam int ADDRESS_WIDTH    = 16;
    localparam int MEMORY_BUS_WIDTH = 32;
    localparam int STROBE_WIDTH     = MEMORY_BUS_WIDTH / 8;
    localparam int WORDS_PER_LINE   = 4;
    localparam int LINE_OFFSET_BITS = $clog2(WORDS_PER_LINE) + 2;
    localparam int LINE_WIDTH       = WORDS_PER_LINE * MEMORY_BUS_WIDTH;

    // Encoding 3 is not named; the controller treats it as a fill.
    typedef enum logic [1:0] {
        OP_FILL      = 2'd0,
        OP_WRITEBACK = 2'd1,
        OP_WB_FILL   = 2'd2
    } line_op_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WB_REQ, ST_WB_GAP, ST_RD_REQ, ST_RD_GAP, ST_DONE
    } ctrl_state_t;

    typedef struct packed {
        logic                        valid;
        logic                        wen;
        logic [ADDRESS_WIDTH-1:0]    address;
        logic [MEMORY_BUS_WIDTH-1:0] data;
        logic [STROBE_WIDTH-1:0]     strobe;
    } Memory_Request;

    typedef struct packed {
        logic                        valid;
        logic [MEMORY_BUS_WIDTH-1:0] data;
    } Memory_Response;
endpackage

// File: rtl/cache_line_mem_ctrl.sv
// Breaks a cache line fill / writeback / writeback-then-fill into single-word
// Memory transactions, each followed by one idle gap cycle.
module cache_line_mem_ctrl
    import cache_line_mem_ctrl_pkg::*;
#(
    parameter int WORDS_PER_LINE = cache_line_mem_ctrl_pkg::WORDS_PER_LINE,
    parameter int ADDRESS_WIDTH  = cache_line_mem_ctrl_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH     = cache_line_mem_ctrl_pkg::MEMORY_BUS_WIDTH,
    parameter int STROBE_WIDTH   = cache_line_mem_ctrl_pkg::STROBE_WIDTH,
    localparam int IDXW          = $clog2(WORDS_PER_LINE),
    localparam int LAW           = ADDRESS_WIDTH - IDXW - 2,
    localparam int LW            = WORDS_PER_LINE * DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  line_op_t       req_op,
    input  logic [LAW-1:0] req_fill_addr,
    input  logic [LAW-1:0] req_wb_addr,
    input  logic [LW-1:0]  req_wb_line,
    output logic           done_valid,
    output logic [LW-1:0]  done_line,
    output logic           busy,
    output Memory_Request  MemoryRequest,
    input  Memory_Response MemoryResponse
);
    localparam logic [IDXW-1:0] LAST = IDXW'(WORDS_PER_LINE - 1);

    ctrl_state_t     state, state_n;
    logic [IDXW-1:0] idx, idx_n;
    line_op_t        op_q;
    logic [LAW-1:0]  fill_q, wb_q, fill_src, wb_src;
    logic [LW-1:0]   line_q, line_src, buf_q, buf_n, done_line_n;
    Memory_Request   req_n;
    logic            accept, word_done, has_wb;

    assign accept    = req_valid && req_ready;
    assign word_done = MemoryRequest.valid && MemoryResponse.valid;
    assign has_wb    = (req_op == OP_WRITEBACK) || (req_op == OP_WB_FILL);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        buf_n    = buf_q;
        // The first request is built in the acceptance cycle, before the latches load.
        fill_src = (state == ST_IDLE) ? req_fill_addr : fill_q;
        wb_src   = (state == ST_IDLE) ? req_wb_addr   : wb_q;
        line_src = (state == ST_IDLE) ? req_wb_line   : line_q;
        case (state)
            ST_IDLE: if (accept) begin
                idx_n   = '0;
                state_n = has_wb ? ST_WB_REQ : ST_RD_REQ;
            end
            ST_WB_REQ: if (word_done) state_n = ST_WB_GAP;
            ST_RD_REQ: if (word_done) begin
                state_n = ST_RD_GAP;
                buf_n[idx*DATA_WIDTH +: DATA_WIDTH] = MemoryResponse.data;
            end
            ST_WB_GAP: begin
                idx_n = idx + 1'b1;
                if (idx == LAST) state_n = (op_q == OP_WB_FILL) ? ST_RD_REQ : ST_DONE;
                else             state_n = ST_WB_REQ;
            end
            ST_RD_GAP: begin
                idx_n   = idx + 1'b1;
                state_n = (idx == LAST) ? ST_DONE : ST_RD_REQ;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase

        // Request fields derive from the next state so MemoryRequest is a pure register.
        req_n = '0;
        if (state_n == ST_WB_REQ) begin
            req_n.valid   = 1'b1;
            req_n.wen     = 1'b1;
            req_n.address = {wb_src, idx_n, 2'b00};
            req_n.data    = line_src[idx_n*DATA_WIDTH +: DATA_WIDTH];
            req_n.strobe  = {STROBE_WIDTH{1'b1}};
        end else if (state_n == ST_RD_REQ) begin
            req_n.valid   = 1'b1;
            req_n.address = {fill_src, idx_n, 2'b00};
        end

        done_line_n = '0;
        if (state_n == ST_DONE && op_q != OP_WRITEBACK) done_line_n = buf_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            idx           <= '0;
            op_q          <= OP_FILL;
            fill_q        <= '0;
            wb_q          <= '0;
            line_q        <= '0;
            buf_q         <= '0;
            MemoryRequest <= '0;
            done_valid    <= 1'b0;
            done_line     <= '0;
            busy          <= 1'b0;
            req_ready     <= 1'b1;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            buf_q         <= buf_n;
            MemoryRequest <= req_n;
            done_valid    <= (state_n == ST_DONE);
            done_line     <= done_line_n;
            busy          <= (state_n != ST_IDLE);
            req_ready     <= (state_n == ST_IDLE);
            if (accept) begin
                op_q   <= has_wb ? req_op : OP_FILL;
                fill_q <= req_fill_addr;
                wb_q   <= req_wb_addr;
                line_q <= req_wb_line;
            end
        end
    end
endmodule

// File: tb/tb_cache_line_mem_ctrl.sv
// Directed bench: line operations against a small delayed word memory, with
// per-word request logging, latency, gap and field-stability checks.
module tb_cache_line_mem_ctrl;
    import cache_line_mem_ctrl_pkg::*;

    localparam int WPL   = WORDS_PER_LINE;
    localparam int LW    = LINE_WIDTH;
    localparam int LAW   = ADDRESS_WIDTH - LINE_OFFSET_BITS;
    localparam int DELAY = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req_valid = 1'b0;
    logic           req_ready;
    line_op_t       req_op = OP_FILL;
    logic [LAW-1:0] req_fill_addr = '0;
    logic [LAW-1:0] req_wb_addr = '0;
    logic [LW-1:0]  req_wb_line = '0;
    logic           done_valid;
    logic [LW-1:0]  done_line;
    logic           busy;
    Memory_Request  mem_req;
    Memory_Response mem_resp;

    always #5 clk = ~clk;

    cache_line_mem_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_fill_addr(req_fill_addr), .req_wb_addr(req_wb_addr),
        .req_wb_line(req_wb_line), .done_valid(done_valid), .done_line(done_line),
        .busy(busy), .MemoryRequest(mem_req), .MemoryResponse(mem_resp)
    );

    // Word memory: answers in the DELAY-th cycle of a held request, counter cleared after.
    logic [31:0] ram [0:1023];
    int          mcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_resp <= '0;
            mcnt     <= 0;
            for (int k = 0; k < 4; k++) begin
                ram[10'h040 + k] <= 32'(k + 1);
                ram[10'h100 + k] <= 32'hC0DE0000 + 32'(k);
                ram[10'h140 + k] <= 32'h50000000 + 32'(k);
            end
        end else if (mem_resp.valid) begin
            mem_resp.valid <= 1'b0;
            mcnt           <= 0;
        end else if (mem_req.valid) begin
            if (mcnt == DELAY - 2) begin
                mem_resp.valid <= 1'b1;
                mem_resp.data  <= mem_req.wen ? 32'h0 : ram[mem_req.address[11:2]];
                if (mem_req.wen) ram[mem_req.address[11:2]] <= mem_req.data;
                mcnt <= 0;
            end else begin
                mcnt <= mcnt + 1;
            end
        end
    end

    int checks = 0, errors = 0, done_cnt = 0;
    Memory_Request log_q[$];
    Memory_Request prev_req;
    logic          prev_resp;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: gap after every completion, fields frozen while waiting.
    always @(negedge clk) begin
        if (rst) begin
            prev_req  <= '0;
            prev_resp <= 1'b0;
        end else begin
            if (prev_req.valid) begin
                if (prev_resp) chk("gap_after_word", 128'(mem_req.valid), 128'(0));
                else           chk("req_stable", 128'(mem_req), 128'(prev_req));
            end
            if (mem_req.valid && mem_resp.valid) log_q.push_back(mem_req);
            if (done_valid) done_cnt++;
            prev_req  <= mem_req;
            prev_resp <= mem_resp.valid;
        end
    end

    typedef struct {
        line_op_t       op;
        logic [LAW-1:0] fill;
        logic [LAW-1:0] wb;
        logic [LW-1:0]  line;
        logic [LW-1:0]  exp;
    } vec_t;
    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input string tag);
        int n, phases, k;
        logic has_wb, has_rd;
        Memory_Request e;
        has_wb = (v.op == OP_WRITEBACK) || (v.op == OP_WB_FILL);
        has_rd = (v.op != OP_WRITEBACK);
        phases = int'(has_wb) + int'(has_rd);
        log_q.delete();
        req_op = v.op; req_fill_addr = v.fill; req_wb_addr = v.wb; req_wb_line = v.line;
        req_valid = 1'b1;
        chk({tag, " ready"}, 128'(req_ready), 128'(1));
        tick;
        req_valid = 1'b0; req_op = OP_WB_FILL; req_fill_addr = '1; req_wb_addr = '1;
        req_wb_line = {4{32'hDEADBEEF}};
        chk({tag, " busy"}, 128'(busy), 128'(1));
        n = 0;
        while (!done_valid && n < 200) begin tick; n++; end
        chk({tag, " latency"}, 128'(n), 128'(phases * WPL * (DELAY + 1)));
        chk({tag, " line"}, done_line, v.exp);
        tick;
        chk({tag, " one_pulse"}, 128'(done_valid), 128'(0));
        chk({tag, " idle"}, 128'({busy, req_ready}), 128'(2'b01));
        chk({tag, " nwords"}, 128'(log_q.size()), 128'(phases * WPL));
        k = 0;
        for (int i = 0; i < WPL; i++) if (has_wb) begin
            e = '0; e.valid = 1'b1; e.wen = 1'b1; e.strobe = 4'hF;
            e.address = {v.wb, 2'(i), 2'b00};
            e.data    = v.line[i*32 +: 32];
            if (k < log_q.size()) chk({tag, " wr_word"}, 128'(log_q[k]), 128'(e));
            k++;
        end
        for (int i = 0; i < WPL; i++) if (has_rd) begin
            e = '0; e.valid = 1'b1;
            e.address = {v.fill, 2'(i), 2'b00};
            if (k < log_q.size()) chk({tag, " rd_word"}, 128'(log_q[k]), 128'(e));
            k++;
        end
    endtask

    initial begin
        int n, d;
        vecs[0] = '{OP_FILL, 12'h010, 12'h000, '0, 128'h00000004_00000003_00000002_00000001};
        vecs[1] = '{OP_WRITEBACK, 12'h000, 12'h020,
                    128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001, '0};
        vecs[2] = '{OP_WB_FILL, 12'h040, 12'h030,
                    128'h33330004_33330003_33330002_33330001,
                    128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000};
        vecs[3] = '{line_op_t'(2'd3), 12'h050, 12'h060, {4{32'h66666666}},
                    128'h50000003_50000002_50000001_50000000};
        vecs[4] = '{OP_FILL, 12'h020, 12'h000, '0, 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001};
        vecs[5] = '{OP_WB_FILL, 12'h040, 12'h040,
                    128'h44440004_44440003_44440002_44440001,
                    128'h44440004_44440003_44440002_44440001};

        #12;
        chk("rst MemoryRequest", 128'(mem_req), 128'(0));
        chk("rst done/busy/ready", 128'({done_valid, busy, req_ready}), 128'(3'b001));
        chk("rst done_line", done_line, '0);
        tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // req_valid held high: second op handshakes only in the cycle after done_valid.
        req_op = OP_FILL; req_fill_addr = 12'h010; req_valid = 1'b1;
        tick;
        n = 0;
        while (!done_valid && n < 200) begin
            chk("hold ready_low", 128'(req_ready), 128'(0));
            tick; n++;
        end
        chk("hold first_done", 128'(done_valid), 128'(1));
        chk("hold ready_in_done", 128'(req_ready), 128'(0));
        tick;
        chk("hold ready_after_done", 128'({busy, req_ready}), 128'(2'b01));
        tick;
        chk("hold second_accept", 128'({busy, req_ready}), 128'(2'b10));
        req_valid = 1'b0;
        n = 0;
        while (!done_valid && n < 200) begin tick; n++; end
        chk("hold second_line", done_line, 128'h00000004_00000003_00000002_00000001);
        tick;

        // Reset while the third word of a fill is outstanding.
        req_op = OP_FILL; req_fill_addr = 12'h050; req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        n = 0;
        while (!(mem_req.valid && mem_req.address[3:2] == 2'd2) && n < 200) begin tick; n++; end
        chk("abort reached_word2", 128'(n < 200), 128'(1));
        d = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("abort req_valid", 128'(mem_req.valid), 128'(0));
        chk("abort busy/ready", 128'({busy, req_ready}), 128'(2'b01));
        tick; tick;
        rst = 1'b0;
        repeat (30) tick;
        chk("abort no_done", 128'(done_cnt), 128'(d));
        run_vec(vecs[0], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
